dmem_resp: RTL
==============

// Module: dmem_resp
// PURPOSE
//  Data-memory responder for the single-cycle core's load/store port. Decodes data_addr, serves
//  combinational reads and commits byte-enabled writes at the clock edge. Hosts a small MMIO block:
//  a tohost/halt register, a 64-bit cycle counter and a scratch register. Sits between the core's
//  data_* outputs and the testbench/top level.
// PARAMETERS
//  DEPTH_WORDS  4096           RAM depth in 32-bit words; power of 2, >= 2.
//  MMIO_BASE    32'h8000_0000  Base of the 16-byte MMIO window; 16-byte aligned, outside RAM range.
// PORTS
//  clk         in   1   Clock; all state updates on the rising edge.
//  rst         in   1   Reset; asynchronous, active-high.
//  data_addr   in   32  Word-aligned byte address from the core ([1:0] ignored).
//  data_wen    in   1   Write strobe; a write commits at the next rising clk edge.
//  data_be     in   4   Byte-lane enables; be[i] selects wdata[8i+7:8i].
//  data_wdata  in   32  Lane-positioned write data.
//  data_rdata  out  32  Read data, combinational from data_addr; full 32-bit word.
//  halt        out  1   Sticky; set by the first write to TOHOST.
//  tohost      out  32  Current TOHOST register value.
//  bus_err     out  1   Sticky; set by an illegal write (see below).
// BEHAVIOUR
//  - Reset: halt=0, tohost=0, bus_err=0, cycle counter=0, scratch=0. RAM contents are not cleared.
//  - Decode:
//    - RAM hit when data_addr < DEPTH_WORDS*4; index = data_addr[log2(DEPTH_WORDS)+1:2].
//    - MMIO hit when data_addr[31:4] == MMIO_BASE[31:4].
//    - Anything else is unmapped.
//  - Read: zero-latency combinational read. Unmapped addresses read 32'h0.
//    - Read-during-write to the same word returns the OLD word. The new value is visible the
//      cycle after the edge.
//  - Write: committed only when data_wen=1 AND data_be!=0. Only the enabled lanes are updated;
//    the other lanes keep their value. data_wen=1 with be=0 is a no-op, not an error.
//  - MMIO map (offset = data_addr[3:2]):
//    - 0x0 TOHOST: R/W with byte merge. Any committed write sets halt=1 on the same edge.
//    - 0x4 CYCLE_LO: read-only, counter[31:0].
//    - 0x8 CYCLE_HI: read-only, counter[63:32].
//    - 0xC SCRATCH: R/W with byte merge.
//  - Cycle counter: 64-bit. Increments by 1 on every edge while halt=0 and holds while halt=1.
//    Wraps from 2^64-1 to 0. The increment of the halting edge still occurs.
//  - bus_err is set on the next edge by a committed-condition write to an unmapped address or to
//    CYCLE_LO/CYCLE_HI; such writes change no state. It stays set until rst.
//  - Simultaneous events: a TOHOST write and a counter increment on the same edge both take effect.
//    A subsequent TOHOST write after halt=1 still updates tohost; halt stays 1.
//  - Reset asserted mid-write: the write is discarded. halt, tohost, bus_err, counter and scratch
//    are forced to their reset values immediately. The RAM word is not guaranteed.
// CONFIGURATION
//  DMEM_MMIO_EN: when defined, the MMIO window is decoded as above.
//    When undefined, the MMIO window is treated as unmapped: its reads return 0 and its writes set
//    bus_err. The halt and tohost ports remain and are tied to 0; no counter or scratch
//    flops are built.
// STRUCTURE
//  - Shared package core_pkg:
//    - MMIO offset constants: MMIO_TOHOST=4'h0, MMIO_CYCLE_LO=4'h4, MMIO_CYCLE_HI=4'h8,
//      MMIO_SCRATCH=4'hC.
//    - Default MMIO_BASE.
//    - A byte-merge function merge_be(old, new, be).
//  - Sub-module dmem_ram: DEPTH_WORDS x 32 array with an async read port and a synchronous
//    byte-lane write port. Decode, MMIO registers and the error logic live in dmem_resp.
// TESTING
//  1. After reset: read 0x8000_0000 -> 0; halt=0, bus_err=0; CYCLE_LO counts 1,2,3 on successive
//     edges after reset release.
//  2. Write 0x0000_0010, be=4'b1111, wdata=32'hDEAD_BEEF; then be=4'b0100, wdata=32'h00AA_0000.
//     Reading 0x10 -> 32'hDEAA_BEEF.
//  3. In the write cycle to 0x10, data_rdata shows the old word. The next cycle shows the new word.
//  4. Write TOHOST with 32'h1, be=4'hF -> halt=1 and tohost=1 after the edge. CYCLE_LO then holds
//     constant for 10 cycles.
//  5. Write to 0x4000_0000 and to CYCLE_HI -> bus_err=1 next cycle, no RAM/register change.
//     be=0 writes leave bus_err=0.
//  6. Assert rst during a SCRATCH write of 32'h1234_5678 -> SCRATCH, halt, tohost, counter and
//     bus_err read back 0.
//     Build without DMEM_MMIO_EN -> MMIO reads 0, MMIO writes set bus_err.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and helpers for the core's data-memory responder.
// Holds the MMIO register offsets, the default MMIO base and the byte-lane merge helper.
package core_pkg;

  localparam logic [3:0]  MMIO_TOHOST       = 4'h0;
  localparam logic [3:0]  MMIO_CYCLE_LO     = 4'h4;
  localparam logic [3:0]  MMIO_CYCLE_HI     = 4'h8;
  localparam logic [3:0]  MMIO_SCRATCH      = 4'hC;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  // Lanes with be[i]=1 take new_w, the rest keep old_w.
  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH_WORDS x 32 data RAM: asynchronous read port, synchronous byte-lane write port.
// Contents are not reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Read is taken from the array before the edge, so a same-word write shows the old value.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: RAM decode, optional MMIO block (TOHOST/halt, 64-bit cycle counter,
// SCRATCH) enabled by DMEM_MMIO_EN, and a sticky bus error for illegal writes.
module dmem_resp
  import core_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic        w_ram_hit;
  logic        w_mmio_win;
  logic        w_commit;
  logic        w_bad_wr;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_mmio_rdata;
  logic        r_bus_err;

  // DEPTH_WORDS is a power of two, so "below DEPTH_WORDS*4" means all upper bits are zero.
  assign w_ram_hit  = (data_addr >> (AW + 2)) == 32'd0;
  assign w_mmio_win = data_addr[31:4] == MMIO_BASE[31:4];
  assign w_commit   = data_wen && (data_be != 4'b0000);

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_commit && w_ram_hit),
    .i_be    (data_be),
    .i_addr  (data_addr[AW+1:2]),
    .i_wdata (data_wdata),
    .o_rdata (w_ram_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [3:0]  w_off;
  logic        w_wr_tohost;
  logic        w_wr_scratch;
  logic        r_halt;
  logic [31:0] r_tohost;
  logic [63:0] r_cycle;
  logic [31:0] r_scratch;

  assign w_off        = {data_addr[3:2], 2'b00};
  assign w_wr_tohost  = w_commit && w_mmio_win && (w_off == MMIO_TOHOST);
  assign w_wr_scratch = w_commit && w_mmio_win && (w_off == MMIO_SCRATCH);
  // Writes to RAM, TOHOST and SCRATCH are legal; the cycle registers are read-only.
  assign w_bad_wr     = w_commit && !w_ram_hit && !w_wr_tohost && !w_wr_scratch;

  always_comb begin
    w_mmio_rdata = 32'h0;
    case (w_off)
      MMIO_TOHOST:   w_mmio_rdata = r_tohost;
      MMIO_CYCLE_LO: w_mmio_rdata = r_cycle[31:0];
      MMIO_CYCLE_HI: w_mmio_rdata = r_cycle[63:32];
      MMIO_SCRATCH:  w_mmio_rdata = r_scratch;
      default:       w_mmio_rdata = 32'h0;
    endcase
  end

  // The halting edge still counts because r_halt is sampled before it rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt    <= 1'b0;
      r_tohost  <= 32'h0;
      r_cycle   <= 64'h0;
      r_scratch <= 32'h0;
    end else begin
      if (!r_halt) r_cycle <= r_cycle + 64'd1;
      if (w_wr_tohost) begin
        r_tohost <= merge_be(r_tohost, data_wdata, data_be);
        r_halt   <= 1'b1;
      end
      if (w_wr_scratch) r_scratch <= merge_be(r_scratch, data_wdata, data_be);
    end
  end

  assign halt   = r_halt;
  assign tohost = r_tohost;
`else
  // Without the MMIO block its window is just another unmapped range.
  assign w_mmio_rdata = 32'h0;
  assign w_bad_wr     = w_commit && (!w_ram_hit || w_mmio_win);
  assign halt         = 1'b0;
  assign tohost       = 32'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bus_err <= 1'b0;
    else if (w_bad_wr) r_bus_err <= 1'b1;
  end

  assign bus_err = r_bus_err;

  assign data_rdata = w_ram_hit  ? w_ram_rdata  :
                      w_mmio_win ? w_mmio_rdata : 32'h0;

endmodule
